// File: rtl/minterm_sweep_ctrl_pkg.sv
// rtl/minterm_sweep_ctrl_pkg.sv - shared types and widths for the minterm sweep controller
package minterm_sweep_ctrl_pkg;

    localparam int VEC_W    = 7;
    localparam int CNT_W    = 8;
    localparam int SETTLE_W = 4;

    localparam logic [VEC_W-1:0] VEC_LAST = 7'd127;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/minterm_sweep_ctrl_settle_timer.sv
// rtl/minterm_sweep_ctrl_settle_timer.sv - loadable settle down-counter with zero flag
module settle_timer
    import minterm_sweep_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                zero
);

    localparam logic [SETTLE_W-1:0] ONE = 1;

    logic [SETTLE_W-1:0] cnt;

    // Free-runs down to zero; the FSM only looks at it while in SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/minterm_sweep_ctrl.sv
// rtl/minterm_sweep_ctrl.sv - walks all 128 input vectors and tallies evaluator minterms
module minterm_sweep_ctrl
    import minterm_sweep_ctrl_pkg::*;
#(
    parameter int SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [VEC_W-1:0] vec,
    input  logic             z_in,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] count,
    output logic             found,
    output logic [VEC_W-1:0] first_min,
    output logic [VEC_W-1:0] last_min
);

    localparam bit HAS_SETTLE = (SETTLE > 0);
    // The timer is loaded with SETTLE-1 so that SETTLE is entered for exactly SETTLE cycles.
    localparam int SETTLE_LOAD_I = HAS_SETTLE ? SETTLE - 1 : 0;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_LOAD_I);
    localparam state_t ST_STEP = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;

    state_t state;
    logic   tmr_load;
    logic   tmr_zero;

    always_comb begin
        tmr_load = 1'b0;
        if (HAS_SETTLE && !abort) begin
            if (state == ST_IDLE && start) begin
                tmr_load = 1'b1;
            end
            if (state == ST_SAMPLE && vec != VEC_LAST) begin
                tmr_load = 1'b1;
            end
        end
    end

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            count     <= '0;
            found     <= 1'b0;
            first_min <= '0;
            last_min  <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        vec       <= '0;
                        count     <= '0;
                        found     <= 1'b0;
                        first_min <= '0;
                        last_min  <= '0;
                        busy      <= 1'b1;
                        state     <= ST_STEP;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (tmr_zero) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    // Abort wins over the sample taken in this same cycle.
                    if (abort) begin
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        if (z_in) begin
                            count    <= count + CNT_W'(1);
                            last_min <= vec;
                            found    <= 1'b1;
                            if (!found) begin
                                first_min <= vec;
                            end
                        end
                        if (vec == VEC_LAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            vec   <= vec + VEC_W'(1);
                            state <= ST_STEP;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
